// File: rtl/divider_radix.sv
// Iterative signed/unsigned restoring divider that retires STEP_BITS quotient bits per clock.
// Divide-by-zero and signed MIN/-1 skip the iteration and return fixed results.
module divider_radix #(
   parameter int DATA_BITS = 32,
   parameter int STEP_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 sign,
   input  logic [DATA_BITS-1:0] dividend,
   input  logic [DATA_BITS-1:0] divisor,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] quotient,
   output logic [DATA_BITS-1:0] remainder,
   output logic                 div_zero,
   output logic                 overflow
);

   localparam int STEPS = DATA_BITS / STEP_BITS;
   localparam int CW    = $clog2(STEPS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           r_state;
   logic [CW-1:0]        r_count;
   logic [DATA_BITS-1:0] r_quo;
   logic [DATA_BITS-1:0] r_rem;
   logic [DATA_BITS-1:0] r_dsr;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [DATA_BITS-1:0] r_quotient;
   logic [DATA_BITS-1:0] r_remainder;
   logic                 r_div_zero;
   logic                 r_overflow;

   logic                 w_dvd_neg;
   logic                 w_dsr_neg;
   logic [DATA_BITS-1:0] w_dvd_mag;
   logic [DATA_BITS-1:0] w_dsr_mag;
   logic                 w_is_zero;
   logic                 w_is_ovf;

   assign w_dvd_neg = sign & dividend[DATA_BITS-1];
   assign w_dsr_neg = sign & divisor[DATA_BITS-1];
   assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
   assign w_dsr_mag = w_dsr_neg ? (~divisor + 1'b1) : divisor;
   assign w_is_zero = (divisor == '0);
   assign w_is_ovf  = sign && (dividend == {1'b1, {(DATA_BITS-1){1'b0}}}) && (&divisor);

   // r_quo starts as the dividend magnitude and shifts left; quotient bits fill from the bottom.
   logic [DATA_BITS-1:0] w_rem [0:STEP_BITS];
   logic [DATA_BITS-1:0] w_quo [0:STEP_BITS];

   assign w_rem[0] = r_rem;
   assign w_quo[0] = r_quo;

   generate
      for (genvar gi = 0; gi < STEP_BITS; gi++) begin : g_step
         logic [DATA_BITS:0] w_sh;
         logic [DATA_BITS:0] w_diff;
         assign w_sh   = {w_rem[gi], w_quo[gi][DATA_BITS-1]};
         assign w_diff = w_sh - {1'b0, r_dsr};
         // Partial remainder stays below 2*divisor, so bit DATA_BITS of the difference is the borrow.
         assign w_rem[gi+1] = w_diff[DATA_BITS] ? w_sh[DATA_BITS-1:0] : w_diff[DATA_BITS-1:0];
         assign w_quo[gi+1] = {w_quo[gi][DATA_BITS-2:0], ~w_diff[DATA_BITS]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_dsr       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_zero  <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_div_zero <= 1'b0;
                  r_overflow <= 1'b0;
                  if (w_is_zero) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                     r_div_zero  <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_is_ovf) begin
                     r_quotient  <= dividend;
                     r_remainder <= '0;
                     r_overflow  <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_quo   <= w_dvd_mag;
                     r_rem   <= '0;
                     r_dsr   <= w_dsr_mag;
                     r_neg_q <= w_dvd_neg ^ w_dsr_neg;
                     r_neg_r <= w_dvd_neg;
                     r_count <= '0;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_quo   <= w_quo[STEP_BITS];
               r_rem   <= w_rem[STEP_BITS];
               r_count <= r_count + 1'b1;
               // The last iteration writes the sign-corrected result directly.
               if (r_count == CW'(STEPS - 1)) begin
                  r_quotient  <= r_neg_q ? (~w_quo[STEP_BITS] + 1'b1) : w_quo[STEP_BITS];
                  r_remainder <= r_neg_r ? (~w_rem[STEP_BITS] + 1'b1) : w_rem[STEP_BITS];
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign div_zero  = r_div_zero;
   assign overflow  = r_overflow;

endmodule
